// File: rtl/mdio_master_cfg_if.sv
// Host command and MDIO pad signals of the MDIO management master.
// master = the MDIO master block; slave = host/PHY side driving commands and MDIO_IN.
interface mdio_master_cfg_if;
   logic        MDIO_START;
   logic [31:0] T_DATA;
   logic        MDIO_IN;
   logic        MDC;
   logic        MDIO_OUT;
   logic        MDIO_OE;
   logic [15:0] RD_DATA;
   logic        DATA_RDY;
   logic        DONE;
   logic        BUSY;
   logic        FRAME_ERR;
   logic        NO_ACK;
   logic [5:0]  BIT_CNT;

   modport master (
      input  MDIO_START, T_DATA, MDIO_IN,
      output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, DONE, BUSY, FRAME_ERR, NO_ACK, BIT_CNT
   );

   modport slave (
      output MDIO_START, T_DATA, MDIO_IN,
      input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, DONE, BUSY, FRAME_ERR, NO_ACK, BIT_CNT
   );
endinterface

// File: rtl/mdio_master_cfg.sv
// Clause 22/45 MDIO master: programmable MDC divider, optional preamble, TA ack check.
// Frame = (PRE_LEN+32) bits of 2*CLK_DIV clk each; START is ignored while BUSY.
module mdio_master_cfg #(
   parameter int CLK_DIV = 2,
   parameter int PRE_LEN = 32
) (
   input  logic               clk,
   input  logic               reset,
   mdio_master_cfg_if.master  bus
);

   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_CMD, ST_TA, ST_DATA} state_t;

   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]      PRE_CNT  = 6'(PRE_LEN);
   localparam bit              HAS_PRE  = (PRE_LEN > 0);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             half_q, half_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [31:0]      frame_q, frame_d;
   logic [15:0]      shadow_q, shadow_d;
   logic             nack_q, nack_d;
   logic             mdc_q, mdc_d;
   logic             out_q, out_d;
   logic             oe_q, oe_d;
   logic [15:0]      rd_data_q, rd_data_d;
   logic             data_rdy_q, data_rdy_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             frame_err_q, frame_err_d;
   logic             no_ack_q, no_ack_d;

   logic             start_legal;
   logic             is_read;

   // Returns {oe, out} for the bit that starts in phase st with cnt bits remaining.
   function automatic logic [1:0] drive_bit(state_t st, logic [5:0] cnt, logic [31:0] fr);
      logic [4:0] idx;
      logic [1:0] res;
      res = 2'b00;
      idx = 5'd0;
      case (st)
         ST_PRE:  res = 2'b11;
         ST_CMD:  begin
            idx = 5'(cnt + 6'd17);
            res = {1'b1, fr[idx]};
         end
         ST_TA:   begin
            idx = 5'(cnt + 6'd15);
            res = fr[29] ? 2'b00 : {1'b1, fr[idx]};
         end
         ST_DATA: begin
            idx = 5'(cnt - 6'd1);
            res = fr[29] ? 2'b00 : {1'b1, fr[idx]};
         end
         default: res = 2'b00;
      endcase
      return res;
   endfunction

   assign start_legal = (bus.T_DATA[31:30] == 2'b00) ||
                        ((bus.T_DATA[31:30] == 2'b01) &&
                         ((bus.T_DATA[29:28] == 2'b01) || (bus.T_DATA[29:28] == 2'b10)));
   assign is_read     = frame_q[29];

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      half_d      = half_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      shadow_d    = shadow_q;
      nack_d      = nack_q;
      mdc_d       = mdc_q;
      out_d       = out_q;
      oe_d        = oe_q;
      rd_data_d   = rd_data_q;
      busy_d      = busy_q;
      data_rdy_d  = 1'b0;
      done_d      = 1'b0;
      frame_err_d = 1'b0;
      no_ack_d    = 1'b0;

      if (state_q == ST_IDLE) begin
         if (bus.MDIO_START) begin
            if (start_legal) begin
               frame_d = bus.T_DATA;
               busy_d  = 1'b1;
               div_d   = '0;
               half_d  = 1'b0;
               mdc_d   = 1'b0;
               nack_d  = 1'b0;
               if (HAS_PRE) begin
                  state_d = ST_PRE;
                  cnt_d   = PRE_CNT;
               end else begin
                  state_d = ST_CMD;
                  cnt_d   = 6'd14;
               end
               {oe_d, out_d} = drive_bit(state_d, cnt_d, bus.T_DATA);
            end else begin
               frame_err_d = 1'b1;
            end
         end
      end else if (div_q != DIV_LAST) begin
         div_d = div_q + 1'b1;
      end else begin
         div_d = '0;
         if (!half_q) begin
            // MDC rising edge: read-side sampling point
            half_d = 1'b1;
            mdc_d  = 1'b1;
            if (is_read && state_q == ST_TA && cnt_q == 6'd1)
               nack_d = bus.MDIO_IN;
            if (is_read && state_q == ST_DATA)
               shadow_d = {shadow_q[14:0], bus.MDIO_IN};
         end else begin
            half_d = 1'b0;
            mdc_d  = 1'b0;
            if (cnt_q != 6'd1) begin
               cnt_d = cnt_q - 6'd1;
               {oe_d, out_d} = drive_bit(state_q, cnt_d, frame_q);
            end else if (state_q == ST_DATA) begin
               state_d = ST_IDLE;
               cnt_d   = 6'd0;
               oe_d    = 1'b0;
               out_d   = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (is_read) begin
                  rd_data_d  = shadow_q;
                  data_rdy_d = 1'b1;
                  no_ack_d   = nack_q;
               end
            end else begin
               case (state_q)
                  ST_PRE:  begin state_d = ST_CMD;  cnt_d = 6'd14; end
                  ST_CMD:  begin state_d = ST_TA;   cnt_d = 6'd2;  end
                  default: begin state_d = ST_DATA; cnt_d = 6'd16; end
               endcase
               {oe_d, out_d} = drive_bit(state_d, cnt_d, frame_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         half_q      <= 1'b0;
         cnt_q       <= 6'd0;
         frame_q     <= 32'd0;
         shadow_q    <= 16'd0;
         nack_q      <= 1'b0;
         mdc_q       <= 1'b0;
         out_q       <= 1'b0;
         oe_q        <= 1'b0;
         rd_data_q   <= 16'd0;
         data_rdy_q  <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         no_ack_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         half_q      <= half_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         shadow_q    <= shadow_d;
         nack_q      <= nack_d;
         mdc_q       <= mdc_d;
         out_q       <= out_d;
         oe_q        <= oe_d;
         rd_data_q   <= rd_data_d;
         data_rdy_q  <= data_rdy_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         no_ack_q    <= no_ack_d;
      end
   end

   assign bus.MDC       = mdc_q;
   assign bus.MDIO_OUT  = out_q;
   assign bus.MDIO_OE   = oe_q;
   assign bus.RD_DATA   = rd_data_q;
   assign bus.DATA_RDY  = data_rdy_q;
   assign bus.DONE      = done_q;
   assign bus.BUSY      = busy_q;
   assign bus.FRAME_ERR = frame_err_q;
   assign bus.NO_ACK    = no_ack_q;
   assign bus.BIT_CNT   = cnt_q;

endmodule

// File: tb/tb_mdio_master_cfg.sv
// Directed bench: instance a (CLK_DIV=2, PRE_LEN=32) and instance b (CLK_DIV=1, PRE_LEN=0).
// Inputs change and outputs are observed on the falling clock edge.
module tb_mdio_master_cfg;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] t_data;
   logic        mdio_in;
   logic        sel_b;

   int vec_cnt;
   int err_cnt;

   mdio_master_cfg_if if_a ();
   mdio_master_cfg_if if_b ();

   mdio_master_cfg #(.CLK_DIV(2), .PRE_LEN(32)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
   mdio_master_cfg #(.CLK_DIV(1), .PRE_LEN(0))  dut_b (.clk(clk), .reset(rst_n), .bus(if_b));

   assign if_a.MDIO_START = start & ~sel_b;
   assign if_b.MDIO_START = start & sel_b;
   assign if_a.T_DATA     = t_data;
   assign if_b.T_DATA     = t_data;
   assign if_a.MDIO_IN    = mdio_in;
   assign if_b.MDIO_IN    = mdio_in;

   logic        obs_mdc, obs_out, obs_oe, obs_rdy, obs_done, obs_busy, obs_ferr, obs_nack;
   logic [15:0] obs_rd;
   logic [5:0]  obs_cnt;

   assign obs_mdc  = sel_b ? if_b.MDC       : if_a.MDC;
   assign obs_out  = sel_b ? if_b.MDIO_OUT  : if_a.MDIO_OUT;
   assign obs_oe   = sel_b ? if_b.MDIO_OE   : if_a.MDIO_OE;
   assign obs_rdy  = sel_b ? if_b.DATA_RDY  : if_a.DATA_RDY;
   assign obs_done = sel_b ? if_b.DONE      : if_a.DONE;
   assign obs_busy = sel_b ? if_b.BUSY      : if_a.BUSY;
   assign obs_ferr = sel_b ? if_b.FRAME_ERR : if_a.FRAME_ERR;
   assign obs_nack = sel_b ? if_b.NO_ACK    : if_a.NO_ACK;
   assign obs_rd   = sel_b ? if_b.RD_DATA   : if_a.RD_DATA;
   assign obs_cnt  = sel_b ? if_b.BIT_CNT   : if_a.BIT_CNT;

   // Captured per-bit observations; vector bit (nbits-1-k) holds frame bit k, so MSB-first.
   logic [63:0] cap_out, cap_oe, cap_mdc_lo, cap_mdc_hi, cap_busy;
   int          cap_cnt [64];
   logic        done_early, err_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_start(input logic sel, input logic [31:0] td);
      sel_b  = sel;
      t_data = td;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Steps through nbits bit periods from the low half of bit 0, acting as the PHY.
   task automatic play_frame(input int nbits, input int div, input logic [63:0] phy,
                             input int inj_k, input logic [31:0] inj_td);
      cap_out = '0; cap_oe = '0; cap_mdc_lo = '0; cap_mdc_hi = '0; cap_busy = '0;
      done_early = 1'b0;
      err_seen   = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         mdio_in = phy[nbits-1-k];
         if (k == inj_k) begin
            start  = 1'b1;
            t_data = inj_td;
         end
         cap_out[nbits-1-k]    = obs_out;
         cap_oe[nbits-1-k]     = obs_oe;
         cap_mdc_lo[nbits-1-k] = obs_mdc;
         cap_busy[nbits-1-k]   = obs_busy;
         cap_cnt[k]            = int'(obs_cnt);
         done_early = done_early | obs_done;
         err_seen   = err_seen | obs_ferr;
         for (int h = 0; h < 2*div; h++) begin
            @(negedge clk);
            start = 1'b0;
            if (h == div-1) cap_mdc_hi[nbits-1-k] = obs_mdc;
            if (h != 2*div-1) begin
               done_early = done_early | obs_done;
               err_seen   = err_seen | obs_ferr;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; t_data = 32'd0; mdio_in = 1'b1; sel_b = 1'b0;
      repeat (3) @(negedge clk);
      vec_cnt++; if ({if_a.MDC, if_a.MDIO_OUT, if_a.MDIO_OE, if_a.DATA_RDY, if_a.DONE, if_a.BUSY, if_a.FRAME_ERR, if_a.NO_ACK} !== 8'h00) begin err_cnt++; $display("FAIL reset_flags_a got %b want 00000000", {if_a.MDC, if_a.MDIO_OUT, if_a.MDIO_OE, if_a.DATA_RDY, if_a.DONE, if_a.BUSY, if_a.FRAME_ERR, if_a.NO_ACK}); end
      vec_cnt++; if (if_a.RD_DATA !== 16'h0000 || if_a.BIT_CNT !== 6'd0) begin err_cnt++; $display("FAIL reset_data_a got rd=%h cnt=%0d want 0000/0", if_a.RD_DATA, if_a.BIT_CNT); end
      vec_cnt++; if ({if_b.MDC, if_b.MDIO_OE, if_b.BUSY, if_b.DONE, if_b.BIT_CNT} !== 10'd0) begin err_cnt++; $display("FAIL reset_b got %b want 0", {if_b.MDC, if_b.MDIO_OE, if_b.BUSY, if_b.DONE, if_b.BIT_CNT}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      do_start(1'b0, 32'h5082_ABCD);
      vec_cnt++; if (obs_busy !== 1'b1) begin err_cnt++; $display("FAIL wr_busy_start got %b want 1", obs_busy); end
      play_frame(64, 2, {64{1'b1}}, -1, 32'd0);
      vec_cnt++; if (cap_out !== 64'hFFFF_FFFF_5082_ABCD) begin err_cnt++; $display("FAIL wr_stream got %h want ffffffff5082abcd", cap_out); end
      vec_cnt++; if (cap_oe !== {64{1'b1}}) begin err_cnt++; $display("FAIL wr_oe got %h want all ones", cap_oe); end
      vec_cnt++; if (cap_mdc_lo !== 64'd0 || cap_mdc_hi !== {64{1'b1}}) begin err_cnt++; $display("FAIL wr_mdc got lo=%h hi=%h want 0/all ones", cap_mdc_lo, cap_mdc_hi); end
      vec_cnt++; if (cap_busy !== {64{1'b1}} || done_early !== 1'b0) begin err_cnt++; $display("FAIL wr_busy got %h early_done=%b want all ones/0", cap_busy, done_early); end
      vec_cnt++; if (cap_cnt[0] != 32 || cap_cnt[31] != 1 || cap_cnt[32] != 14 || cap_cnt[46] != 2 || cap_cnt[48] != 16 || cap_cnt[63] != 1) begin err_cnt++; $display("FAIL wr_bitcnt got %0d %0d %0d %0d %0d %0d want 32 1 14 2 16 1", cap_cnt[0], cap_cnt[31], cap_cnt[32], cap_cnt[46], cap_cnt[48], cap_cnt[63]); end
      vec_cnt++; if ({obs_done, obs_busy, obs_rdy, obs_mdc, obs_oe, obs_out} !== 6'b100000) begin err_cnt++; $display("FAIL wr_end got %b want 100000", {obs_done, obs_busy, obs_rdy, obs_mdc, obs_oe, obs_out}); end
      @(negedge clk);
      vec_cnt++; if (obs_done !== 1'b0) begin err_cnt++; $display("FAIL wr_done_pulse got %b want 0", obs_done); end
   endtask

   task automatic test_read_ack();
      do_start(1'b0, 32'h6082_0000);
      play_frame(64, 2, {{47{1'b1}}, 1'b0, 16'h1234}, -1, 32'd0);
      vec_cnt++; if (cap_oe !== 64'hFFFF_FFFF_FFFC_0000) begin err_cnt++; $display("FAIL rd_oe got %h want fffffffffffc0000", cap_oe); end
      vec_cnt++; if (cap_out !== 64'hFFFF_FFFF_6080_0000) begin err_cnt++; $display("FAIL rd_stream got %h want ffffffff60800000", cap_out); end
      vec_cnt++; if (obs_rd !== 16'h1234) begin err_cnt++; $display("FAIL rd_data got %h want 1234", obs_rd); end
      vec_cnt++; if ({obs_rdy, obs_done, obs_nack, obs_busy} !== 4'b1100) begin err_cnt++; $display("FAIL rd_flags got %b want 1100", {obs_rdy, obs_done, obs_nack, obs_busy}); end
      @(negedge clk);
      vec_cnt++; if (obs_rdy !== 1'b0 || obs_rd !== 16'h1234) begin err_cnt++; $display("FAIL rd_hold got rdy=%b rd=%h want 0/1234", obs_rdy, obs_rd); end
   endtask

   task automatic test_read_noack();
      do_start(1'b0, 32'h6082_0000);
      play_frame(64, 2, {64{1'b1}}, -1, 32'd0);
      vec_cnt++; if (obs_rd !== 16'hFFFF) begin err_cnt++; $display("FAIL nack_data got %h want ffff", obs_rd); end
      vec_cnt++; if ({obs_rdy, obs_done, obs_nack} !== 3'b111) begin err_cnt++; $display("FAIL nack_flags got %b want 111", {obs_rdy, obs_done, obs_nack}); end
      @(negedge clk);
      vec_cnt++; if (obs_nack !== 1'b0) begin err_cnt++; $display("FAIL nack_pulse got %b want 0", obs_nack); end
   endtask

   task automatic test_illegal();
      logic [31:0] bad [2];
      logic        mdc_seen;
      bad[0] = 32'hC000_0000;
      bad[1] = 32'h4000_0000;
      for (int i = 0; i < 2; i++) begin
         do_start(1'b0, bad[i]);
         vec_cnt++; if ({obs_ferr, obs_busy, obs_mdc} !== 3'b100) begin err_cnt++; $display("FAIL illegal%0d_flags got %b want 100", i, {obs_ferr, obs_busy, obs_mdc}); end
         mdc_seen = 1'b0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mdc_seen = mdc_seen | obs_mdc | obs_busy | obs_ferr;
         end
         vec_cnt++; if (mdc_seen !== 1'b0) begin err_cnt++; $display("FAIL illegal%0d_quiet got %b want 0", i, mdc_seen); end
      end
      vec_cnt++; if (obs_rd !== 16'hFFFF) begin err_cnt++; $display("FAIL illegal_rd_hold got %h want ffff", obs_rd); end
   endtask

   task automatic test_back_to_back();
      do_start(1'b0, 32'h0082_0010);
      play_frame(64, 2, {64{1'b1}}, -1, 32'd0);
      vec_cnt++; if (cap_out !== 64'hFFFF_FFFF_0082_0010) begin err_cnt++; $display("FAIL b2b_addr_stream got %h want ffffffff00820010", cap_out); end
      vec_cnt++; if ({obs_done, obs_rdy} !== 2'b10 || obs_rd !== 16'hFFFF) begin err_cnt++; $display("FAIL b2b_addr_end got done/rdy=%b rd=%h want 10/ffff", {obs_done, obs_rdy}, obs_rd); end
      do_start(1'b0, 32'h3082_0000);
      vec_cnt++; if (obs_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_restart got busy=%b want 1", obs_busy); end
      play_frame(64, 2, {{47{1'b1}}, 1'b0, 16'hBEEF}, -1, 32'd0);
      vec_cnt++; if (cap_out !== 64'hFFFF_FFFF_3080_0000 || cap_oe !== 64'hFFFF_FFFF_FFFC_0000) begin err_cnt++; $display("FAIL b2b_rd_stream got out=%h oe=%h want ffffffff30800000/fffffffffffc0000", cap_out, cap_oe); end
      vec_cnt++; if (obs_rd !== 16'hBEEF || {obs_rdy, obs_done, obs_nack} !== 3'b110) begin err_cnt++; $display("FAIL b2b_rd_end got rd=%h flags=%b want beef/110", obs_rd, {obs_rdy, obs_done, obs_nack}); end
      @(negedge clk);
   endtask

   task automatic test_fast_write_busy();
      do_start(1'b1, 32'h5082_ABCD);
      play_frame(32, 1, {64{1'b1}}, 10, 32'hC000_0000);
      vec_cnt++; if (cap_out[31:0] !== 32'h5082_ABCD || cap_oe[31:0] !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL fast_stream got out=%h oe=%h want 5082abcd/ffffffff", cap_out[31:0], cap_oe[31:0]); end
      vec_cnt++; if (err_seen !== 1'b0 || done_early !== 1'b0) begin err_cnt++; $display("FAIL fast_ignore got ferr=%b early_done=%b want 0/0", err_seen, done_early); end
      vec_cnt++; if (cap_cnt[0] != 14 || cap_mdc_hi[31:0] !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL fast_timing got cnt0=%0d mdc_hi=%h want 14/ffffffff", cap_cnt[0], cap_mdc_hi[31:0]); end
      vec_cnt++; if ({obs_done, obs_busy, obs_rdy} !== 3'b100) begin err_cnt++; $display("FAIL fast_done64 got %b want 100", {obs_done, obs_busy, obs_rdy}); end
      @(negedge clk);
   endtask

   task automatic test_abort();
      do_start(1'b1, 32'h5082_ABCD);
      play_frame(20, 1, {64{1'b1}}, -1, 32'd0);
      vec_cnt++; if (obs_busy !== 1'b1 || obs_cnt !== 6'd12) begin err_cnt++; $display("FAIL abort_mid got busy=%b cnt=%0d want 1/12", obs_busy, obs_cnt); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vec_cnt++; if ({obs_mdc, obs_out, obs_oe, obs_busy, obs_done, obs_rdy, obs_ferr, obs_nack, obs_cnt} !== 14'd0) begin err_cnt++; $display("FAIL abort_reset got %b want 0", {obs_mdc, obs_out, obs_oe, obs_busy, obs_done, obs_rdy, obs_ferr, obs_nack, obs_cnt}); end
      @(negedge clk);
      do_start(1'b1, 32'h6082_0000);
      play_frame(32, 1, {32'd0, 14'h3FFF, 1'b1, 1'b0, 16'h5A5A}, -1, 32'd0);
      vec_cnt++; if (cap_oe[31:0] !== 32'hFFFC_0000) begin err_cnt++; $display("FAIL abort_rd_oe got %h want fffc0000", cap_oe[31:0]); end
      vec_cnt++; if (obs_rd !== 16'h5A5A || {obs_rdy, obs_done, obs_nack} !== 3'b110) begin err_cnt++; $display("FAIL abort_rd_end got rd=%h flags=%b want 5a5a/110", obs_rd, {obs_rdy, obs_done, obs_nack}); end
      @(negedge clk);
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_write();
      test_read_ack();
      test_read_noack();
      test_illegal();
      test_back_to_back();
      test_fast_write_busy();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
